// File: rtl/srd_digitized.sv
// Digit-serial restoring divider: resolves SIZEOF_DIGITS quotient bits per clock
// and returns quotient/remainder with a start/done handshake and divide-by-zero flag.

module srd_step #(
  parameter int SIZEA = 64,
  parameter int SIZEB = 32
) (
  input  logic [SIZEB:0]   p,
  input  logic [SIZEA-1:0] a,
  input  logic [SIZEB-1:0] b,
  output logic [SIZEB:0]   p_n,
  output logic [SIZEA-1:0] a_n
);
  logic [SIZEB:0] ps;
  logic           ge;

  // The guard bit in p keeps the shifted partial remainder from overflowing the compare.
  always_comb begin
    ps  = {p[SIZEB-1:0], a[SIZEA-1]};
    ge  = (ps >= {1'b0, b});
    p_n = ge ? (ps - {1'b0, b}) : ps;
    a_n = {a[SIZEA-2:0], ge};
  end
endmodule

module srd_digitized #(
  parameter int SIZEA         = 64,
  parameter int SIZEB         = 32,
  parameter int SIZEOF_DIGITS = 1,
  parameter int DIGITS        = SIZEA / SIZEOF_DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZEA-1:0] a,
  input  logic [SIZEB-1:0] b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [SIZEA-1:0] q,
  output logic [SIZEB-1:0] r
);
  localparam int             CW   = $clog2(DIGITS + 1);
  localparam logic [CW-1:0]  LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

  state_t           state, state_d;
  logic [SIZEA-1:0] a_r, a_d;
  logic [SIZEB-1:0] b_r, b_d;
  logic [SIZEB:0]   p_r, p_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             dz, dz_d;
  logic [SIZEA-1:0] q_d;
  logic [SIZEB-1:0] r_d;
  logic             busy_d, done_d, dbz_d;

  logic [SIZEOF_DIGITS:0][SIZEB:0]   pc;
  logic [SIZEOF_DIGITS:0][SIZEA-1:0] ac;

  assign pc[0] = p_r;
  assign ac[0] = a_r;

  for (genvar g = 0; g < SIZEOF_DIGITS; g++) begin : g_step
    srd_step #(.SIZEA(SIZEA), .SIZEB(SIZEB)) u_step (
      .p  (pc[g]),
      .a  (ac[g]),
      .b  (b_r),
      .p_n(pc[g+1]),
      .a_n(ac[g+1])
    );
  end

  always_comb begin
    state_d = state;
    a_d     = a_r;
    b_d     = b_r;
    p_d     = p_r;
    cnt_d   = cnt;
    dz_d    = dz;
    q_d     = q;
    r_d     = r;
    busy_d  = busy;
    done_d  = 1'b0;
    dbz_d   = dbz;
    case (state)
      ST_IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        p_d     = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        dbz_d   = 1'b0;
        dz_d    = (b == '0);
        state_d = (b == '0) ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        a_d   = ac[SIZEOF_DIGITS];
        p_d   = pc[SIZEOF_DIGITS];
        cnt_d = cnt + CW'(1);
        if (cnt == LAST) state_d = ST_FIN;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        // On divide-by-zero A still holds the raw dividend captured at accept.
        if (dz) begin
          q_d   = '1;
          r_d   = a_r[SIZEB-1:0];
          dbz_d = 1'b1;
        end else begin
          q_d = a_r;
          r_d = p_r[SIZEB-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      p_r   <= '0;
      cnt   <= '0;
      dz    <= 1'b0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      state <= state_d;
      a_r   <= a_d;
      b_r   <= b_d;
      p_r   <= p_d;
      cnt   <= cnt_d;
      dz    <= dz_d;
      q     <= q_d;
      r     <= r_d;
      busy  <= busy_d;
      done  <= done_d;
      dbz   <= dbz_d;
    end
  end
endmodule

// File: tb/tb_srd_digitized.sv
// Directed bench for srd_digitized: one instance at 1 bit/cycle, one at 4 bits/cycle.

module tb_srd_digitized;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic        busy1, done1, dbz1, busy4, done4, dbz4;
  logic [63:0] q1, q4;
  logic [31:0] r1, r4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  srd_digitized #(.SIZEA(64), .SIZEB(32), .SIZEOF_DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .a(a_in), .b(b_in), .start(start1),
    .busy(busy1), .done(done1), .dbz(dbz1), .q(q1), .r(r1)
  );

  srd_digitized #(.SIZEA(64), .SIZEB(32), .SIZEOF_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .a(a_in), .b(b_in), .start(start4),
    .busy(busy4), .done(done4), .dbz(dbz4), .q(q4), .r(r4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, then count edges to done and cycles with busy high.
  task automatic run_op(input bit w4, input logic [63:0] av, input logic [31:0] bv,
                        input int lat, input logic [63:0] eq, input logic [31:0] er,
                        input logic edz, input string tag);
    int n, bc;
    @(negedge clk);
    a_in = av; b_in = bv;
    if (w4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    bc = w4 ? int'(busy4) : int'(busy1);
    n  = 0;
    while (!(w4 ? done4 : done1) && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (!(w4 ? done4 : done1)) bc += w4 ? int'(busy4) : int'(busy1);
    end
    chk({tag, "_lat"},  64'(n), 64'(lat));
    chk({tag, "_busy"}, 64'(bc), 64'(lat));
    chk({tag, "_q"},    w4 ? q4 : q1, eq);
    chk({tag, "_r"},    64'(w4 ? r4 : r1), 64'(er));
    chk({tag, "_dbz"},  64'(w4 ? dbz4 : dbz1), 64'(edz));
    chk({tag, "_bsy0"}, 64'(w4 ? busy4 : busy1), 64'd0);
  endtask

  initial begin
    int  n, m;
    logic seen;

    #12;
    chk("rst_out", {busy1, done1, dbz1, busy4, done4, dbz4}, 64'd0);
    chk("rst_q", q1 | q4, 64'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);

    run_op(1'b0, 64'd100, 32'd7, 65, 64'd14, 32'd2, 1'b0, "basic");
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 17, 64'h1_0000_0001, 32'd0, 1'b0, "dig4");
    run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 32'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h9ABC_DEF0, 1'b1, "dbz");
    run_op(1'b0, 64'd5, 32'd9, 65, 64'd0, 32'd5, 1'b0, "small");
    run_op(1'b0, 64'd0, 32'd1, 65, 64'd0, 32'd0, 1'b0, "zero");
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 65, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0, "maxdiv1");

    // A second request mid-run must be dropped; operands change under the running op.
    @(negedge clk); a_in = 64'd1000; b_in = 32'd10; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); a_in = 64'd50; b_in = 32'd3; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    n = 0;
    while (!done1 && n < 300) begin @(posedge clk); #1; n++; end
    chk("hs_done", 64'(done1), 64'd1);
    chk("hs_q", q1, 64'd100);
    chk("hs_r", 64'(r1), 64'd0);
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; seen |= done1 | busy1; end
    chk("hs_drop", 64'(seen), 64'd0);

    // Start held high: back-to-back operations.
    @(negedge clk); a_in = 64'd100; b_in = 32'd7; start1 = 1'b1;
    n = 0;
    while (!done1 && n < 300) begin @(posedge clk); #1; n++; end
    m = 0;
    do begin @(posedge clk); #1; m++; end while (!done1 && m < 300);
    start1 = 1'b0;
    chk("b2b_space", 64'(m), 64'd66);
    chk("b2b_q", q1, 64'd14);

    // Asynchronous reset in the middle of a run.
    repeat (3) @(posedge clk);
    @(negedge clk); a_in = 64'd1000; b_in = 32'd3; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (20) @(posedge clk);
    chk("mid_busy", 64'(busy1), 64'd1);
    #3; rst = 1'b0;
    #1;
    chk("arst_flags", {busy1, done1, dbz1}, 64'd0);
    chk("arst_q", q1, 64'd0);
    chk("arst_r", 64'(r1), 64'd0);
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      seen |= busy1 | done1 | dbz1 | (|q1) | (|r1) | busy4 | done4 | dbz4 | (|q4) | (|r4);
    end
    chk("idle_quiet", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
